// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - opcode encodings seen by the ALU
//   - sequencer FSM state encoding
//   - divider iteration count and a small two's-complement magnitude helper
package alu_pkg;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpMul  = 5'b00010;
  localparam logic [4:0] OpDiv  = 5'b00011;
  localparam logic [4:0] OpShr  = 5'b00100;
  localparam logic [4:0] OpShra = 5'b00101;
  localparam logic [4:0] OpShl  = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01010;
  localparam logic [4:0] OpOr   = 5'b01011;
  localparam logic [4:0] OpNeg  = 5'b01100;
  localparam logic [4:0] OpNot  = 5'b01101;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StDivIter = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam int unsigned DivIterations = 32;

  // Magnitude of a signed 32-bit value; 32'h8000_0000 maps to itself, which is
  // the correct unsigned magnitude for the divider.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the control unit, the sequencer and the ALU.
//   start/opcode/src_a/src_b : request from the control unit
//   busy/done/z_hi/z_lo/div_by_zero : status and result back to the control unit
//   alu_y/alu_a/alu_b/alu_opcode : registered ALU inputs; alu_result : ALU output
// slave  : the sequencer side
// master : the control unit / ALU side
interface alu_op_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] alu_result;
  logic [31:0] alu_y;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic        busy;
  logic        done;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        div_by_zero;

  modport slave (
    input  start, opcode, src_a, src_b, alu_result,
    output alu_y, alu_a, alu_b, alu_opcode, busy, done, z_hi, z_lo, div_by_zero
  );

  modport master (
    output start, opcode, src_a, src_b, alu_result,
    input  alu_y, alu_a, alu_b, alu_opcode, busy, done, z_hi, z_lo, div_by_zero
  );
endinterface

// File: rtl/alu_op_sequencer_divider.sv
// Unsigned iterative restoring divider, one quotient bit per cycle, MSB first.
//   clock, clear    : clock and asynchronous active-high reset
//   start_i         : load operands and begin (one-cycle pulse)
//   dividend_i      : unsigned dividend
//   divisor_i       : unsigned divisor (non-zero; zero is filtered upstream)
//   quotient_o      : quotient, valid when finish_o is high
//   remainder_o     : remainder, valid when finish_o is high
//   finish_o        : one-cycle strobe the cycle after the last iteration
module seq_divider_unsigned
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        finish_o
);

  localparam int unsigned CntW = $clog2(DivIterations);

  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;
  logic            fin_q, fin_d;

  // The quotient register doubles as the dividend shift register.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});

    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    fin_d    = 1'b0;

    if (start_i) begin
      rem_d    = '0;
      quo_d    = dividend_i;
      dvs_d    = divisor_i;
      cnt_d    = CntW'(DivIterations - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      // Remainder stays below the divisor, so the restored value fits in 32 bits.
      rem_d = fits ? diff[31:0] : shifted[31:0];
      quo_d = {quo_q[30:0], fits};
      if (cnt_q == '0) begin
        active_d = 1'b0;
        fin_d    = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      fin_q    <= fin_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign finish_o    = fin_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller sequencing one ALU operation per request, with signed
// DIV supplied by an internal restoring divider.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset; aborts any operation in flight
//   bus   : request/status/result and ALU-side signals (alu_op_sequencer_if.slave)
// Parameter DIV_ENABLE: 1 = DIV runs on the divider, 0 = DIV is an unknown opcode.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter bit DIV_ENABLE = 1'b1
) (
  input logic                clock,
  input logic                clear,
  alu_op_sequencer_if.slave  bus
);

  logic [2:0]  state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic        dbz_q, dbz_d;

  logic        div_start;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_fin;
  logic        is_div;
  logic        signs_differ;

  assign is_div       = DIV_ENABLE && (op_q == OpDiv);
  assign signs_differ = a_q[31] ^ b_q[31];

  seq_divider_unsigned u_divider (
    .clock       (clock),
    .clear       (clear),
    .start_i     (div_start),
    .dividend_i  (abs32(a_q)),
    .divisor_i   (abs32(b_q)),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .finish_o    (div_fin)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    z_hi_d    = z_hi_q;
    z_lo_d    = z_lo_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          y_d     = bus.src_a;
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          op_d    = bus.opcode;
          dbz_d   = 1'b0;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        if (!is_div) begin
          state_d = StCapture;
        end else if (b_q == '0) begin
          z_lo_d  = 32'hFFFF_FFFF;
          z_hi_d  = a_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else begin
          div_start = 1'b1;
          state_d   = StDivIter;
        end
      end
      StCapture: begin
        {z_hi_d, z_lo_d} = bus.alu_result;
        state_d          = StDone;
      end
      StDivIter: begin
        if (div_fin) begin
          // Truncating division: quotient sign from XOR, remainder follows dividend.
          z_lo_d  = signs_differ ? (~div_quo + 32'd1) : div_quo;
          z_hi_d  = a_q[31] ? (~div_rem + 32'd1) : div_rem;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.alu_y       = y_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_opcode  = op_q;
  assign bus.z_hi        = z_hi_q;
  assign bus.z_lo        = z_lo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == StLoad) || (state_q == StCapture) ||
                           (state_q == StDivIter);
  assign bus.done        = (state_q == StDone);

endmodule
